// File: rtl/draw_pkg.sv
// Shared constants and types for the screen/sprite draw engine.
// Holds the default screen and sprite geometry, the widths of the ROM
// address and the VGA x/y coordinates, and the engine state encoding.
package draw_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int SPRITE_DIM = 40;

  localparam int ADDR_W = 15;  // 160*120-1 = 19199 fits in 15 bits
  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int COL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } draw_state_t;

endpackage

// File: rtl/screen_draw_engine_if.sv
// Bus bundle between a draw requester and the draw engine.
//   start/stop          : single-cycle command inputs to the engine
//   spriteMode/xInit/yInit/black : draw parameters, sampled on start
//   romAddr / romData   : ROM read port (data returns one cycle after address)
//   x/y/colour/plot     : VGA adapter write port
//   busy/done           : status (busy while drawing, done = one-cycle pulse)
// Handshake: start is a request taken only while the engine is idle; it is
// not held and has no ready, so a start while busy is simply dropped. plot
// acts as a valid with no back-pressure: x/y/colour are meaningful exactly
// in cycles where plot=1 and the sink must accept every such cycle.
// master = requester/ROM/VGA side, slave = engine side.
interface screen_draw_engine_if;
  import draw_pkg::*;

  logic              start;
  logic              stop;
  logic              spriteMode;
  logic [X_W-1:0]    xInit;
  logic [Y_W-1:0]    yInit;
  logic              black;
  logic [ADDR_W-1:0] romAddr;
  logic [COL_W-1:0]  romData;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [COL_W-1:0]  colour;
  logic              plot;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, spriteMode, xInit, yInit, black, romData,
    input  romAddr, x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, stop, spriteMode, xInit, yInit, black, romData,
    output romAddr, x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/xy_sweep_counter.sv
// Raster sweep counter: walks col 0..w_last, then row 0..h_last, while a
// linear address counts up by one per step so the address equals
// row*width+col without a multiplier.
//   clr    : synchronous clear of col/row/addr (start of a draw)
//   en     : advance one pixel
//   w_last/h_last : last column/row index of the current area
//   last   : high while col/row sit on the final pixel
module xy_sweep_counter
  import draw_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [X_W-1:0]    w_last,
  input  logic [Y_W-1:0]    h_last,
  output logic [X_W-1:0]    col,
  output logic [Y_W-1:0]    row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  assign last = (col == w_last) && (row == h_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clr) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (en) begin
      addr <= addr + 1'b1;
      if (col == w_last) begin
        col <= '0;
        row <= (row == h_last) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/screen_draw_engine.sv
// Copies a full screen (160x120) or a sprite (40x40) from a ROM to a VGA
// adapter write port, offset by an origin, with optional forced black and
// clipping against the visible screen.
//   clk, stateReset : clock, asynchronous active-high reset
//   bus (slave)     : command, ROM and VGA signals (see interface)
//   state_dbg       : current engine state
// Pipeline: in DRAW the address for (col,row) is presented; the ROM answers
// one cycle later, so x/y/plot are registered once to line up with romData.
// FLUSH exists only to emit the plot for the final address.
module screen_draw_engine #(
  parameter int SCREEN_W   = draw_pkg::SCREEN_W,
  parameter int SCREEN_H   = draw_pkg::SCREEN_H,
  parameter int SPRITE_DIM = draw_pkg::SPRITE_DIM
) (
  input  logic                  clk,
  input  logic                  stateReset,
  screen_draw_engine_if.slave   bus,
  output draw_pkg::draw_state_t state_dbg
);
  import draw_pkg::*;

  localparam logic [X_W-1:0] SCR_X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SCR_Y_LAST = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] SPR_X_LAST = X_W'(SPRITE_DIM - 1);
  localparam logic [Y_W-1:0] SPR_Y_LAST = Y_W'(SPRITE_DIM - 1);
  localparam logic [X_W:0]   X_LIM      = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   Y_LIM      = (Y_W+1)'(SCREEN_H);

  draw_state_t       state;
  logic              spr_r;
  logic              black_r;
  logic [X_W-1:0]    xo_r;
  logic [Y_W-1:0]    yo_r;
  logic [X_W-1:0]    x_r;
  logic [Y_W-1:0]    y_r;
  logic              plot_r;
  logic              pix_valid;  // a ROM word for a swept pixel arrives now
  logic              busy_r;
  logic              done_r;

  logic [X_W-1:0]    col;
  logic [Y_W-1:0]    row;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              start_ok;
  logic [X_W:0]      x_wide;
  logic [Y_W:0]      y_wide;
  logic              on_screen;

  assign start_ok  = (state == IDLE) && bus.start && !bus.stop;
  // One extra bit so an origin near the right/bottom edge cannot wrap
  // back onto the visible screen.
  assign x_wide    = {1'b0, xo_r} + {1'b0, col};
  assign y_wide    = {1'b0, yo_r} + {1'b0, row};
  assign on_screen = (x_wide < X_LIM) && (y_wide < Y_LIM);

  xy_sweep_counter u_sweep (
    .clk    (clk),
    .rst    (stateReset),
    .clr    (start_ok),
    .en     (state == DRAW),
    .w_last (spr_r ? SPR_X_LAST : SCR_X_LAST),
    .h_last (spr_r ? SPR_Y_LAST : SCR_Y_LAST),
    .col    (col),
    .row    (row),
    .addr   (addr),
    .last   (last)
  );

  always_ff @(posedge clk or posedge stateReset) begin
    if (stateReset) begin
      state     <= IDLE;
      spr_r     <= 1'b0;
      black_r   <= 1'b0;
      xo_r      <= '0;
      yo_r      <= '0;
      x_r       <= '0;
      y_r       <= '0;
      plot_r    <= 1'b0;
      pix_valid <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      plot_r    <= 1'b0;
      pix_valid <= 1'b0;
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (start_ok) begin
            state   <= DRAW;
            spr_r   <= bus.spriteMode;
            black_r <= bus.black;
            xo_r    <= bus.xInit;
            yo_r    <= bus.yInit;
            busy_r  <= 1'b1;
          end
        end
        DRAW: begin
          x_r       <= x_wide[X_W-1:0];
          y_r       <= y_wide[Y_W-1:0];
          plot_r    <= on_screen;
          pix_valid <= 1'b1;
          if (last) state <= FLUSH;
        end
        FLUSH: begin
          state  <= DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Abort overrides everything above, including a same-cycle start.
      if (bus.stop) begin
        state     <= IDLE;
        plot_r    <= 1'b0;
        pix_valid <= 1'b0;
        busy_r    <= 1'b0;
        done_r    <= 1'b0;
      end
    end
  end

  assign bus.romAddr = addr;
  assign bus.x       = x_r;
  assign bus.y       = y_r;
  assign bus.plot    = plot_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  // Colour follows romData in the same cycle it arrives; clipping only
  // gates plot, so colour is still driven for off-screen pixels.
  assign bus.colour  = (pix_valid && !black_r) ? bus.romData : 3'b000;
  assign state_dbg   = state;

endmodule

// File: tb/tb_screen_draw_engine.sv
module tb_screen_draw_engine;
  import draw_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  screen_draw_engine_if bus ();
  draw_state_t state_dbg;

  screen_draw_engine dut (
    .clk        (clk),
    .stateReset (rst),
    .bus        (bus),
    .state_dbg  (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ROM model ----------------
  bit rom_const = 1'b0;

  function automatic logic [2:0] rom_fn(input int a);
    logic [14:0] v;
    v = 15'(a);
    if (rom_const) return 3'b101;
    return v[2:0] ^ v[9:7] ^ v[14:12] ^ 3'(v[5:4]);
  endfunction

  always @(posedge clk) bus.romData <= rom_fn(int'(bus.romAddr));

  // ---------------- scoreboard ----------------
  // entry: {cycle, x, y, colour}
  logic [49:0] exp_q[$];
  logic [31:0] done_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference model: walk the area row by row and list what should appear.
  task automatic push_expect(input bit spr, input int xo, input int yo,
                             input bit blk, input int s, input int stop_at);
    int w, h, i, px, py;
    w = spr ? SPRITE_DIM : SCREEN_W;
    h = spr ? SPRITE_DIM : SCREEN_H;
    i = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = xo + c;
        py = yo + r;
        if ((stop_at == 0 || 2 + i <= stop_at) && px < SCREEN_W && py < SCREEN_H)
          exp_q.push_back({32'(s + 2 + i), 8'(px), 7'(py), blk ? 3'b000 : rom_fn(i)});
        i++;
      end
    end
    if (stop_at == 0) done_q.push_back(32'(s + w * h + 2));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [49:0] e, g;
    if (!rst) begin
      if (bus.plot) begin
        total++;
        g = {32'(cyc), bus.x, bus.y, bus.colour};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL plot_unexpected: cyc=%0d x=%0d y=%0d c=%0d", cyc, bus.x, bus.y, bus.colour);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL plot: got cyc=%0d x=%0d y=%0d c=%0d want cyc=%0d x=%0d y=%0d c=%0d",
                     g[49:18], g[17:10], g[9:3], g[2:0], e[49:18], e[17:10], e[9:3], e[2:0]);
          end
        end
        total++;
        if (bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_during_plot: got=%0d want=1 cyc=%0d", bus.busy, cyc);
        end
      end
      if (bus.done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: cyc=%0d", cyc);
        end else if (done_q[0] != 32'(cyc)) begin
          bad++;
          $display("FAIL done_cycle: got=%0d want=%0d", cyc, done_q[0]);
          void'(done_q.pop_front());
        end else begin
          void'(done_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_draw(input bit spr, input int xo, input int yo,
                            input bit blk, input int stop_at, output int s);
    @(posedge clk); #1;
    bus.spriteMode = spr;
    bus.xInit      = 8'(xo);
    bus.yInit      = 7'(yo);
    bus.black      = blk;
    bus.start      = 1'b1;
    s = cyc;
    push_expect(spr, xo, yo, blk, s, stop_at);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_romAddr"}, int'(bus.romAddr), 0);
    check({tag, "_x"}, int'(bus.x), 0);
    check({tag, "_y"}, int'(bus.y), 0);
    check({tag, "_colour"}, int'(bus.colour), 0);
    check({tag, "_plot"}, int'(bus.plot), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_state"}, int'(state_dbg), int'(IDLE));
  endtask

  task automatic finish_draw(input int n, input string tag);
    repeat (n + 4) @(posedge clk);
    #1;
    check({tag, "_plots_left"}, exp_q.size(), 0);
    check({tag, "_done_left"}, done_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, xo, yo;
    bit blk;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.spriteMode = 1'b0;
    bus.xInit = '0; bus.yInit = '0; bus.black = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // sprite at (10,20)
    start_draw(1'b1, 10, 20, 1'b0, 0, s);
    finish_draw(1600, "sprite");

    // full screen from (0,0)
    start_draw(1'b0, 0, 0, 1'b0, 0, s);
    finish_draw(19200, "screen");

    // sprite clipped at the bottom-right corner
    start_draw(1'b1, 150, 100, 1'b0, 0, s);
    finish_draw(1600, "clip");

    // forced black over a constant ROM
    rom_const = 1'b1;
    start_draw(1'b1, 30, 40, 1'b1, 0, s);
    finish_draw(1600, "black");
    rom_const = 1'b0;

    // abort at cycle 500 with ignored mid-draw starts
    start_draw(1'b1, 5, 5, 1'b0, 500, s);
    for (int k = 1; k <= 500; k++) begin
      bus.start = (k == 100 || k == 200 || k == 500);
      bus.stop  = (k == 500);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("stop_state", int'(state_dbg), int'(IDLE));
    check("stop_busy", int'(bus.busy), 0);
    check("stop_plots_left", exp_q.size(), 0);

    // asynchronous reset mid-draw
    start_draw(1'b1, 20, 10, 1'b0, 0, s);
    repeat (300) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    #1;
    check_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start_draw(1'b1, 60, 30, 1'b0, 0, s);
    finish_draw(1600, "after_reset");

    // random back-to-back sprites: each starts in the IDLE cycle after DONE
    for (int t = 0; t < 6; t++) begin
      xo  = $urandom_range(0, 255);
      yo  = $urandom_range(0, 127);
      blk = 1'($urandom_range(0, 1));
      start_draw(1'b1, xo, yo, blk, 0, s);
      repeat (1600 + 1) @(posedge clk);
    end
    finish_draw(0, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time guard
  initial begin
    #2000000;
    $display("FAIL timeout: cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
